// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, gain coefficient helper and stream beat type
package cordic_pkg;

    localparam real CORDIC_GAIN_INV = 0.6072529350088813;
    localparam int  BEAT_DW         = 16;
    localparam int  BEAT_AW         = 16;

    typedef struct packed {
        logic signed [BEAT_DW-1:0] x;
        logic signed [BEAT_DW-1:0] y;
        logic signed [BEAT_AW-1:0] a;
    } beat_t;

    // round(1/K * 2^(kw-1)), the unsigned Q0.(kw-1) compensation coefficient
    function automatic int calc_gain_coef(input int kw);
        real s;
        s = CORDIC_GAIN_INV;
        for (int i = 1; i < kw; i++) begin
            s = s * 2.0;
        end
        return $rtoi(s + 0.5);
    endfunction

endpackage

// File: rtl/cordic_round_shift.sv
// rtl/cordic_round_shift.sv - round-half-up arithmetic right shift with truncation to OW bits
module cordic_round_shift #(
    parameter int IW = 32,
    parameter int SH = 15,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] in_i,
    output logic signed [OW-1:0] out_o
);

    localparam logic [IW:0] HALF = (IW+1)'(1) << (SH-1);

    // One guard bit so adding the half LSB can never wrap the sign
    logic [IW:0] sum;
    logic        unused_bits;

    assign sum         = {in_i[IW-1], in_i} + HALF;
    assign out_o       = sum[SH +: OW];
    assign unused_bits = ^{sum[IW:SH+OW], sum[SH-1:0]};

endmodule

// File: rtl/cordic_gain_comp.sv
// rtl/cordic_gain_comp.sv - 2-stage CORDIC gain compensation with valid/ready flow control
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int DW = BEAT_DW,
    parameter int AW = BEAT_AW,
    parameter int KW = 16,
    parameter int K  = calc_gain_coef(KW)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    input  logic signed [AW-1:0] a_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic signed [DW-1:0] x_o,
    output logic signed [DW-1:0] y_o,
    output logic signed [AW-1:0] a_o
);

    localparam int                     PW   = DW + KW;
    localparam logic signed [PW-1:0]   COEF = PW'(K);

    logic                 s1_v_q, s1_v_d;
    logic signed [PW-1:0] px_q, px_d, py_q, py_d;
    logic signed [AW-1:0] a1_q, a1_d;
    logic                 s2_v_q, s2_v_d;
    logic signed [DW-1:0] x_q, x_d, y_q, y_d;
    logic signed [AW-1:0] a2_q, a2_d;

    logic                 s1_en, s2_en;
    logic signed [PW-1:0] prod_x, prod_y;
    logic signed [DW-1:0] rx, ry;

    assign prod_x = $signed({{KW{x_i[DW-1]}}, x_i}) * COEF;
    assign prod_y = $signed({{KW{y_i[DW-1]}}, y_i}) * COEF;

    cordic_round_shift #(.IW(PW), .SH(KW-1), .OW(DW)) u_round_x (
        .in_i  (px_q),
        .out_o (rx)
    );

    cordic_round_shift #(.IW(PW), .SH(KW-1), .OW(DW)) u_round_y (
        .in_i  (py_q),
        .out_o (ry)
    );

    // ready_i reaches ready_o combinationally; an empty stage always advances
    always_comb begin
        s2_en  = !s2_v_q || ready_i;
        s1_en  = !s1_v_q || s2_en;

        s1_v_d = s1_en ? valid_i : s1_v_q;
        px_d   = px_q;
        py_d   = py_q;
        a1_d   = a1_q;
        if (s1_en && valid_i) begin
            px_d = prod_x;
            py_d = prod_y;
            a1_d = a_i;
        end

        s2_v_d = s2_en ? s1_v_q : s2_v_q;
        x_d    = x_q;
        y_d    = y_q;
        a2_d   = a2_q;
        if (s2_en && s1_v_q) begin
            x_d  = rx;
            y_d  = ry;
            a2_d = a1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_v_q <= 1'b0;
            px_q   <= '0;
            py_q   <= '0;
            a1_q   <= '0;
            s2_v_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            a2_q   <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            px_q   <= px_d;
            py_q   <= py_d;
            a1_q   <= a1_d;
            s2_v_q <= s2_v_d;
            x_q    <= x_d;
            y_q    <= y_d;
            a2_q   <= a2_d;
        end
    end

    assign ready_o = s1_en;
    assign valid_o = s2_v_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign a_o     = a2_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb/tb_cordic_gain_comp.sv - directed vectors plus scoreboarded streaming for cordic_gain_comp
module tb_cordic_gain_comp;
    import cordic_pkg::*;

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic               valid_i;
    logic               ready_o;
    logic signed [15:0] x_i, y_i, a_i;
    logic               valid_o;
    logic               ready_i;
    logic signed [15:0] x_o, y_o, a_o;

    cordic_gain_comp dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .x_i     (x_i),
        .y_i     (y_i),
        .a_i     (a_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .x_o     (x_o),
        .y_o     (y_o),
        .a_o     (a_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        beat_t              in;
        logic signed [15:0] ex;
        logic signed [15:0] ey;
    } vec_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    beat_t  exp_q[$];
    beat_t  hold;
    logic   stall_prev = 1'b0;
    logic   pending    = 1'b0;
    logic   drv_v = 1'b0, drv_r = 1'b1;
    logic signed [15:0] drv_x = '0, drv_y = '0, drv_a = '0;
    int     n_in = 0, n_out = 0;
    vec_t   vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // floor(v*19898/32768 + 0.5) using integer division with explicit floor
    function automatic logic signed [15:0] gold(input int v);
        longint n, q;
        n = longint'(v) * 19898 + 16384;
        q = n / 32768;
        if (n < 0 && q * 32768 != n) q = q - 1;
        return 16'(q);
    endfunction

    task automatic new_data();
        drv_x = 16'($urandom);
        drv_y = 16'($urandom);
        drv_a = 16'($urandom);
    endtask

    task automatic step();
        beat_t e;
        @(negedge clk_i);
        valid_i = drv_v;
        x_i     = drv_x;
        y_i     = drv_y;
        a_i     = drv_a;
        ready_i = drv_r;
        #1;
        if (stall_prev) begin
            check("stall_valid", longint'(valid_o), 1);
            check("stall_x", longint'(x_o), longint'($signed(hold.x)));
            check("stall_y", longint'(y_o), longint'($signed(hold.y)));
            check("stall_a", longint'(a_o), longint'($signed(hold.a)));
        end
        stall_prev = valid_o && !ready_i;
        hold       = '{x: x_o, y: y_o, a: a_o};
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_x", longint'(x_o), longint'($signed(e.x)));
                check("sb_y", longint'(y_o), longint'($signed(e.y)));
                check("sb_a", longint'(a_o), longint'($signed(e.a)));
            end
            n_out++;
        end
        pending = valid_i && !ready_o;
        if (valid_i && ready_o) begin
            exp_q.push_back('{x: gold(int'(drv_x)), y: gold(int'(drv_y)), a: drv_a});
            n_in++;
        end
    endtask

    task automatic drain(input string name);
        drv_v = 1'b0;
        drv_r = 1'b1;
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
        check(name, longint'(exp_q.size()), 0);
    endtask

    initial begin
        vecs[0] = '{in: '{x: 16384,  y: -16384, a: 5},    ex: 9949,  ey: -9949};
        vecs[1] = '{in: '{x: 32767,  y: -32768, a: -7},   ex: 19897, ey: -19898};
        vecs[2] = '{in: '{x: 1,      y: -1,     a: 100},  ex: 1,     ey: -1};
        vecs[3] = '{in: '{x: 0,      y: 0,      a: -1},   ex: 0,     ey: 0};
        vecs[4] = '{in: '{x: -1,     y: 1,      a: 32767},ex: -1,    ey: 1};
        vecs[5] = '{in: '{x: 1000,   y: -1000,  a: 0},    ex: 607,   ey: -607};

        rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        x_i = '0; y_i = '0; a_i = '0;
        #2;
        check("rst_valid_o", longint'(valid_o), 0);
        check("rst_x_o", longint'(x_o), 0);
        check("rst_y_o", longint'(y_o), 0);
        check("rst_a_o", longint'(a_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        check("ready_after_rst", longint'(ready_o), 1);

        // Directed single beats with latency checks
        for (int i = 0; i < 6; i++) begin
            drv_r = 1'b1;
            drv_v = 1'b1;
            drv_x = vecs[i].in.x;
            drv_y = vecs[i].in.y;
            drv_a = vecs[i].in.a;
            step();
            check("lat0_valid", longint'(valid_o), 0);
            drv_v = 1'b0;
            step();
            check("lat1_valid", longint'(valid_o), 0);
            step();
            check("lat2_valid", longint'(valid_o), 1);
            check("vec_x", longint'(x_o), longint'(vecs[i].ex));
            check("vec_y", longint'(y_o), longint'(vecs[i].ey));
            check("vec_a", longint'(a_o), longint'(vecs[i].in.a));
            step();
            check("lat3_valid", longint'(valid_o), 0);
        end

        // 100 back-to-back beats, no backpressure
        drv_r = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drv_v = 1'b1;
            new_data();
            step();
            check("b2b_ready", longint'(ready_o), 1);
            if (i >= 2) check("b2b_valid", longint'(valid_o), 1);
        end
        drain("b2b_drain");

        // Backpressure on an empty pipe: fills after two beats
        drv_r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!pending) begin
                drv_v = 1'b1;
                new_data();
            end
            step();
            check("stall_ready_o", longint'(ready_o), (i < 2) ? 1 : 0);
        end
        drv_r = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!pending) new_data();
            step();
            check("resume_ready_o", longint'(ready_o), 1);
        end
        drain("stall_drain");
        check("stall_in_out", longint'(n_in), longint'(n_out));

        // Random valid/ready over 10k accepted beats
        begin
            int start_in;
            start_in = n_in;
            for (int c = 0; c < 60000 && (n_in - start_in) < 10000; c++) begin
                drv_r = ($urandom_range(0, 3) != 0);
                if (!pending) begin
                    drv_v = ($urandom_range(0, 3) != 0);
                    new_data();
                end
                step();
            end
            check("rand_accepted", longint'(n_in - start_in), 10000);
        end
        drain("rand_drain");
        check("rand_in_out", longint'(n_in), longint'(n_out));

        // Asynchronous reset with two beats in flight
        drv_r = 1'b0;
        drv_v = 1'b1;
        new_data();
        step();
        new_data();
        step();
        @(posedge clk_i);
        #2;
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        #1;
        check("arst_valid_o", longint'(valid_o), 0);
        check("arst_x_o", longint'(x_o), 0);
        check("arst_y_o", longint'(y_o), 0);
        check("arst_a_o", longint'(a_o), 0);
        exp_q.delete();
        stall_prev = 1'b0;
        pending    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("arst_hold_valid", longint'(valid_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        drv_r  = 1'b1;
        drv_v  = 1'b1;
        drv_x  = 16'sd1234;
        drv_y  = -16'sd4321;
        drv_a  = 16'sd77;
        step();
        drv_v = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 5 && !seen; i++) begin
                step();
                if (valid_o) begin
                    seen = 1'b1;
                    check("post_rst_x", longint'(x_o), longint'(gold(1234)));
                    check("post_rst_y", longint'(y_o), longint'(gold(-4321)));
                    check("post_rst_a", longint'(a_o), 77);
                end
            end
            check("post_rst_seen", longint'(seen), 1);
        end
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
